mult_share_sched: RTL and testbench
===================================

# mult_share_sched

Round-robin scheduler that time-shares one signed WIDTH×WIDTH combinational multiplier core (`mult8s_normal_sklansky` at WIDTH=8) among NREQ requesters. Each requester uses a valid/ready channel. The block registers operands and the product in a fixed two-stage pipeline, like the standalone wrapper. Tagged results go into an in-order response FIFO with backpressure. It sits between the multiplier datapath and the client units that want products.

## Interface
- NREQ, 4 — number of requesters; power of two, 2..8.
- WIDTH, 8 — operand width; product width is 2*WIDTH.
- DEPTH, 4 — response FIFO entries; power of two, ≥2.
- clk  in  1  — single clock, rising edge.
- rst_n  in  1  — reset; **one clock; reset is synchronous and active-low**.
- req_valid  in  NREQ  — per-requester request valid.
- req_a  in  NREQ*WIDTH  — multiplicands; requester i occupies bits [i*WIDTH +: WIDTH]; signed.
- req_b  in  NREQ*WIDTH  — multipliers; same packing; signed.
- req_ready  out  NREQ  — one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- rsp_valid  out  1  — response FIFO non-empty.
- rsp_id  out  log2(NREQ)  — index of the requester that issued the head result.
- rsp_product  out  2*WIDTH  — signed product at the head.
- rsp_ready  in  1  — consumer accepts the head; pop when rsp_valid & rsp_ready.
- busy  out  1  — high when any pipeline stage or FIFO entry is valid.

## Operation
- Requesters hold req_valid and their operands stable until accepted. The block never drops an asserted request.
- Arbitration is round-robin with a priority pointer `ptr`.
  - The grant goes to the first i with req_valid[i], searching from ptr upward with wrap.
  - The block grants at most one requester per cycle.
  - After an accepted transfer by i, ptr ← (i+1) mod NREQ. With no transfer, ptr holds.
- Credit gating: occupancy = s1_v + s2_v + fifo_count.
  - A grant is allowed only when occupancy < DEPTH.
  - A same-cycle pop does not create credit; this gating is deliberately conservative.
  - The FIFO therefore can never overflow.
- req_ready is combinational from req_valid, ptr and occupancy. It never depends on rsp_ready within the same cycle.
- Pipeline:
  - Stage 1 registers {a, b, id, v} on acceptance.
  - The combinational core multiplies the stage-1 operands.
  - Stage 2 registers {product, id, v}.
  - A valid stage-2 entry writes the FIFO on the next edge. No stall is needed because credit guarantees space.
- Arithmetic: two's complement, full 2*WIDTH result, no overflow or truncation. For example, (−128)·(−128) = 0x4000 at WIDTH=8.
- FIFO ordering: responses leave in acceptance order. A simultaneous push and pop keeps the count unchanged.
- Reset, asserted at any time including mid-operation:
  - Clears s1_v, s2_v, the FIFO pointers and count, and sets ptr=0.
  - In-flight results are discarded.
  - Values after reset: req_ready=0, rsp_valid=0, busy=0.
  - Data registers need no reset. rsp_product and rsp_id are don't-care while rsp_valid=0.

## Timing
- Handshake in cycle C: stage 1 valid in C+1, stage 2 valid in C+2, rsp_valid in C+3. Minimum latency is 3 cycles.
- Sustained throughput is one product per cycle while rsp_ready=1 and DEPTH≥4. At DEPTH=2, throughput is bounded by the credit rule.
- With rsp_ready held low, exactly DEPTH requests are accepted. After that req_ready is 0 until a pop. The first new grant comes in the cycle after the pop.
- rsp_valid deasserts in the cycle after the last entry pops, provided no push occurs in the same cycle.

## Structure
- Package `mult_sched_pkg` holds:
  - the defaults for NREQ, WIDTH and DEPTH;
  - the localparams ID_W = $clog2(NREQ) and CNT_W = $clog2(DEPTH)+1;
  - a packed struct `mult_rsp_t` {id, product} used for the FIFO entry and the stage-2 register.
- Sub-module `rr_arbiter` (NREQ) contains the pointer register and the one-hot grant search. Its inputs are req, enable (the credit condition) and accept; its output is a one-hot grant.
- The multiplier core is instantiated unchanged inside the top. The FIFO is inline (register array plus read/write pointers).

## Test plan
- Single request from requester 2 with a=−3, b=5 → accepted in cycle 0; rsp_valid in cycle 3 with rsp_id=2 and rsp_product=0xFFF1.
- All four requesters valid from reset with ptr=0 → grants in order 0,1,2,3 on consecutive cycles. Responses follow in the same order, one per cycle, starting at cycle 3.
- a=−128, b=−128 → 0x4000. a=127, b=−128 → 0xC080. a=0, b=−1 → 0x0000.
- rsp_ready=0, all requesters valid → exactly 4 accepts, then req_ready=0. Raising rsp_ready for one cycle → one pop and one new grant in the following cycle.
- Requesters 0 and 3 held valid continuously → grants alternate 0,3,0,3; neither is starved.
- rst_n low for one cycle while 3 results are in flight → rsp_valid=0, busy=0 and ptr=0 on the next cycle, and no stale response is ever emitted.

Source files
------------

// File: rtl/mult_share_sched_pkg.sv
// Shared parameters and the tagged-product record used by the scheduler.
// The record and the derived widths are sized from the default configuration.
package mult_sched_pkg;
   localparam int NREQ_DEF  = 4;
   localparam int WIDTH_DEF = 8;
   localparam int DEPTH_DEF = 4;
   localparam int ID_W      = $clog2(NREQ_DEF);
   localparam int CNT_W     = $clog2(DEPTH_DEF) + 1;

   typedef struct packed {
      logic [ID_W-1:0]        id;
      logic [2*WIDTH_DEF-1:0] product;
   } mult_rsp_t;
endpackage

// File: rtl/mult8s_normal_sklansky.sv
// Signed WIDTH x WIDTH combinational multiplier core, full-width product.
module mult8s_normal_sklansky #(
   parameter int WIDTH = 8
) (
   input  logic signed [WIDTH-1:0]   a,
   input  logic signed [WIDTH-1:0]   b,
   output logic signed [2*WIDTH-1:0] p
);
   assign p = a * b;
endmodule

// File: rtl/mult_share_sched_rr_arbiter.sv
// Round-robin one-hot arbiter: searches upward from ptr with wrap; ptr moves
// past the winner only when the grant is actually taken.
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            enable,
   input  logic            accept,
   output logic [NREQ-1:0] grant
);
   localparam int PW = $clog2(NREQ);

   logic [PW-1:0] ptr;
   logic [PW-1:0] gidx;
   logic [PW-1:0] idx;
   logic          found;

   // NREQ is a power of two, so PW-bit addition wraps the search naturally
   always_comb begin
      grant = '0;
      gidx  = ptr;
      idx   = '0;
      found = 1'b0;
      for (int off = 0; off < NREQ; off++) begin
         idx = ptr + PW'(off);
         if (enable && !found && req[idx]) begin
            grant[idx] = 1'b1;
            gidx       = idx;
            found      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)      ptr <= '0;
      else if (accept) ptr <= gidx + PW'(1);
   end
endmodule

// File: rtl/mult_share_sched.sv
// Time-shares one signed multiplier among NREQ requesters: round-robin grant,
// two-stage pipeline, in-order tagged response FIFO with credit-based admission.
module mult_share_sched
   import mult_sched_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       req_ready,
   output logic                  rsp_valid,
   output logic [ID_W-1:0]       rsp_id,
   output logic [2*WIDTH-1:0]    rsp_product,
   input  logic                  rsp_ready,
   output logic                  busy
);
   localparam int AW = $clog2(DEPTH);

   logic             s1_v, s2_v;
   logic [WIDTH-1:0] s1_a, s1_b;
   logic [ID_W-1:0]  s1_id, gidx;
   logic [2*WIDTH-1:0] prod;
   mult_rsp_t        s2;
   mult_rsp_t        mem [DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic [CNT_W-1:0] count, occ;
   logic             credit, accept, push, pop;

   // Everything admitted but not yet popped; a same-cycle pop is not counted as credit
   assign occ    = CNT_W'(s1_v) + CNT_W'(s2_v) + count;
   assign credit = rst_n && (occ < CNT_W'(DEPTH));
   assign accept = |(req_valid & req_ready);
   assign push   = s2_v;
   assign pop    = rsp_valid & rsp_ready;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req_valid),
      .enable (credit),
      .accept (accept),
      .grant  (req_ready)
   );

   always_comb begin
      gidx = '0;
      for (int i = 0; i < NREQ; i++)
         if (req_ready[i]) gidx = ID_W'(i);
   end

   mult8s_normal_sklansky #(.WIDTH(WIDTH)) u_core (
      .a (s1_a),
      .b (s1_b),
      .p (prod)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_v  <= 1'b0;
         s2_v  <= 1'b0;
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         s1_v  <= accept;
         s2_v  <= s1_v;
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Data path carries no reset; the valid bits above qualify it
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_a  <= req_a[gidx*WIDTH +: WIDTH];
         s1_b  <= req_b[gidx*WIDTH +: WIDTH];
         s1_id <= gidx;
      end
      s2 <= '{id: s1_id, product: prod};
      if (push) mem[wptr] <= s2;
   end

   assign rsp_valid   = (count != '0);
   assign rsp_id      = mem[rptr].id;
   assign rsp_product = mem[rptr].product;
   assign busy        = s1_v | s2_v | rsp_valid;
endmodule

// File: tb/tb_mult_share_sched.sv
// Bench for mult_share_sched: queue-based reference checked every cycle plus
// directed scenarios with hand-computed literal expectations.
module tb_mult_share_sched;
   localparam int NREQ = 4, WIDTH = 8, DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid, req_ready, refill;
   logic [31:0] req_a, req_b;
   logic        rsp_valid, rsp_ready, busy;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_product;

   int n_cmp = 0;
   int n_bad = 0;

   // values observed by the most recent step()
   logic [3:0]  s_gr;
   logic        s_rv, s_busy;
   logic [1:0]  s_id;
   logic [15:0] s_prod;

   always #5 clk = ~clk;

   mult_share_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_product (rsp_product),
      .rsp_ready   (rsp_ready),
      .busy        (busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model: queue of admitted, unpopped results
   typedef struct {
      int          id;
      logic [15:0] p;
      int          t;
   } ent_t;
   ent_t q[$];
   int   mptr = 0;
   int   cyc  = 0;

   always @(negedge clk) begin
      logic [3:0]         exp_gr;
      logic               exp_rv;
      logic signed [15:0] pp;
      int                 idx;
      exp_gr = '0;
      if (rst_n && q.size() < DEPTH)
         for (int off = 0; off < NREQ; off++) begin
            idx = (mptr + off) % NREQ;
            if (req_valid[idx] && exp_gr == 4'b0) exp_gr[idx] = 1'b1;
         end
      exp_rv = (q.size() > 0) && (q[0].t + 3 <= cyc);
      chk("m_req_ready", 32'(req_ready), 32'(exp_gr));
      chk("m_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("m_busy", 32'(busy), 32'(q.size() != 0));
      if (exp_rv && rsp_valid) begin
         chk("m_rsp_id", 32'(rsp_id), 32'(q[0].id));
         chk("m_rsp_product", 32'(rsp_product), 32'(q[0].p));
      end
      if (!rst_n) begin
         q.delete();
         mptr = 0;
      end else begin
         if (exp_rv && rsp_ready) void'(q.pop_front());
         for (int i = 0; i < NREQ; i++)
            if (req_valid[i] && req_ready[i]) begin
               pp = $signed(req_a[i*8 +: 8]) * $signed(req_b[i*8 +: 8]);
               q.push_back('{id: i, p: pp, t: cyc});
               mptr = (i + 1) % NREQ;
            end
      end
      cyc++;
   end

   // ---------------- stimulus helpers
   task automatic step();
      logic [3:0] acc;
      @(negedge clk);
      acc    = req_valid & req_ready;
      s_gr   = req_ready;
      s_rv   = rsp_valid;
      s_id   = rsp_id;
      s_prod = rsp_product;
      s_busy = busy;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++)
         if (acc[i]) begin
            if (refill[i]) begin
               req_a[i*8 +: 8] = req_a[i*8 +: 8] + 8'd7;
               req_b[i*8 +: 8] = req_b[i*8 +: 8] - 8'd3;
            end else
               req_valid[i] = 1'b0;
         end
   endtask

   task automatic single(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp);
      int k;
      bit got;
      k   = 0;
      got = 0;
      req_a[id*8 +: 8] = a;
      req_b[id*8 +: 8] = b;
      req_valid[id]    = 1'b1;
      while (k < 20 && !got) begin
         step();
         if (s_rv) got = 1;
         else      k++;
      end
      chk("single_seen", 32'(got), 32'd1);
      chk("single_latency", 32'(k), 32'd3);
      chk("single_id", 32'(s_id), 32'(id));
      chk("single_product", 32'(s_prod), 32'(exp));
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1);
   end

   initial begin
      logic [3:0]  gr[7];
      logic        rv[7];
      logic [1:0]  id[7];
      logic [15:0] pr[7];
      int nacc, prev, cur, alt_bad, c0, c3;

      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      refill    = 4'b0000;
      req_valid = 4'b1111;
      req_a     = {8'd4, 8'd3, 8'd2, 8'd1};
      req_b     = {8'hFB, 8'hFC, 8'hFD, 8'hFE};   // -5,-4,-3,-2

      // reset state: nothing granted even with all requesters valid
      step();
      chk("reset_ready", 32'(s_gr), 32'd0);
      chk("reset_rsp_valid", 32'(s_rv), 32'd0);
      chk("reset_busy", 32'(s_busy), 32'd0);
      step();
      rst_n = 1'b1;

      // all four valid from reset: grants 0,1,2,3; responses 3 cycles later in order
      for (int k = 0; k < 7; k++) begin
         step();
         gr[k] = s_gr; rv[k] = s_rv; id[k] = s_id; pr[k] = s_prod;
      end
      chk("rr_grant0", 32'(gr[0]), 32'h1);
      chk("rr_grant1", 32'(gr[1]), 32'h2);
      chk("rr_grant2", 32'(gr[2]), 32'h4);
      chk("rr_grant3", 32'(gr[3]), 32'h8);
      chk("rr_no_early_rsp", 32'(rv[2]), 32'd0);
      for (int k = 3; k < 7; k++) begin
         chk("rr_rsp_valid", 32'(rv[k]), 32'd1);
         chk("rr_rsp_id", 32'(id[k]), 32'(k - 3));
      end
      chk("rr_prod0", 32'(pr[3]), 32'hFFFE);
      chk("rr_prod3", 32'(pr[6]), 32'hFFEC);
      repeat (4) step();

      // single transactions and arithmetic extremes
      single(2, 8'hFD, 8'h05, 16'hFFF1);
      single(0, 8'h80, 8'h80, 16'h4000);
      single(1, 8'h7F, 8'h80, 16'hC080);
      single(3, 8'h00, 8'hFF, 16'h0000);

      // backpressure: exactly DEPTH accepts, then one pop buys one later grant
      rsp_ready = 1'b0;
      refill    = 4'b1111;
      req_valid = 4'b1111;
      nacc      = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (s_gr != 4'b0) nacc++;
      end
      chk("bp_accepts", 32'(nacc), 32'd4);
      chk("bp_ready_low", 32'(s_gr), 32'd0);
      rsp_ready = 1'b1;
      step();
      chk("bp_pop_cycle_no_grant", 32'(s_gr), 32'd0);
      chk("bp_pop_seen", 32'(s_rv), 32'd1);
      rsp_ready = 1'b0;
      step();
      chk("bp_grant_after_pop", 32'($countones(s_gr)), 32'd1);
      step();
      chk("bp_ready_low_again", 32'(s_gr), 32'd0);
      refill    = 4'b0000;
      rsp_ready = 1'b1;
      repeat (20) step();

      // requesters 0 and 3 continuously: alternate, one accept per cycle
      req_valid = 4'b1001;
      refill    = 4'b1001;
      nacc = 0; prev = -1; alt_bad = 0; c0 = 0; c3 = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (s_gr != 4'b0) begin
            nacc++;
            cur = (s_gr == 4'b0001) ? 0 : (s_gr == 4'b1000) ? 3 : 9;
            if (cur == 0) c0++;
            if (cur == 3) c3++;
            if (cur == prev || cur == 9) alt_bad++;
            prev = cur;
         end
      end
      chk("alt_throughput", 32'(nacc), 32'd8);
      chk("alt_order", 32'(alt_bad), 32'd0);
      chk("alt_count0", 32'(c0), 32'd4);
      chk("alt_count3", 32'(c3), 32'd4);
      refill = 4'b0000;
      repeat (10) step();

      // reset with three results in flight
      req_valid = 4'b0111;
      repeat (3) step();
      rst_n = 1'b0;
      step();
      rst_n     = 1'b1;
      req_valid = 4'b1111;
      step();
      chk("midreset_rsp_valid", 32'(s_rv), 32'd0);
      chk("midreset_busy", 32'(s_busy), 32'd0);
      chk("midreset_ptr0_grant", 32'(s_gr), 32'h1);
      repeat (20) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
